// File: rtl/dht11_sched_pkg.sv
// Shared types and constants for the DHT11 read scheduler.
package dht11_sched_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        GAP    = 5'b00010,
        START  = 5'b00100,
        WAIT   = 5'b01000,
        REPORT = 5'b10000
    } state_e;

    localparam int unsigned REQ_FAN  = 0;
    localparam int unsigned REQ_DISP = 1;
    localparam int unsigned N_REQ    = REQ_DISP - REQ_FAN + 1;

endpackage

// File: rtl/dht11_sched_ms_tick.sv
// Millisecond strobe: one-cycle pulse every CLK_PER_MS clocks, phase restartable.
module dht11_sched_ms_tick #(
    parameter int CLK_PER_MS = 100_000
) (
    input  logic clk,
    input  logic reset_p,
    input  logic restart,
    output logic tick
);

    localparam int CW = $clog2(CLK_PER_MS + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick = (cnt_q == CW'(CLK_PER_MS - 1));
        if (restart || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dht11_sched.sv
// DHT11 read scheduler: arbitrates two requesters, serves fresh cache, enforces gap, retries.
module dht11_sched
    import dht11_sched_pkg::*;
#(
    parameter int CLK_PER_MS = 100_000,
    parameter int MIN_GAP_MS = 2000,
    parameter int FRESH_MS   = 1000,
    parameter int PERIOD_MS  = 3000,
    parameter int TIMEOUT_MS = 30,
    parameter int MAX_RETRY  = 2
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [N_REQ-1:0] req,
    input  logic             auto_en,
    output logic [N_REQ-1:0] ack,
    output logic             result_ok,
    output logic             rd_start,
    input  logic             rd_done,
    input  logic             rd_ok,
    input  logic [7:0]       rd_humidity,
    input  logic [7:0]       rd_temperature,
    output logic [7:0]       humidity,
    output logic [7:0]       temperature,
    output logic             data_valid,
    output logic             busy,
    output logic [7:0]       fail_cnt
);

    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [15:0] GAP_LIM   = 16'(MIN_GAP_MS);
    localparam logic [15:0] FRESH_LIM = 16'(FRESH_MS);
    localparam logic [15:0] PER_LIM   = 16'(PERIOD_MS);
    localparam logic [15:0] TO_LIM    = 16'(TIMEOUT_MS);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] pend_q, pend_d;
    logic             pend_auto_q, pend_auto_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [15:0]      age_q, age_d;
    logic [15:0]      gap_q, gap_d;
    logic [15:0]      to_q, to_d;
    logic [7:0]       fail_q, fail_d;
    logic [7:0]       hum_q, hum_d;
    logic [7:0]       temp_q, temp_d;
    logic             valid_q, valid_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             res_q, res_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             tick;
    logic             tick_restart;

    // Realign the ms phase on every start so gap and timeout are never short by a partial ms.
    assign tick_restart = (state_q == START);

    dht11_sched_ms_tick #(
        .CLK_PER_MS (CLK_PER_MS)
    ) u_ms_tick (
        .clk     (clk),
        .reset_p (reset_p),
        .restart (tick_restart),
        .tick    (tick)
    );

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        fail_d      = fail_q;
        hum_d       = hum_q;
        temp_d      = temp_q;
        valid_d     = valid_q;
        ack_d       = '0;
        res_d       = 1'b0;
        start_d     = 1'b0;
        pend_d      = ~ack_q & (pend_q | req);
        pend_auto_d = pend_auto_q | (auto_en && (age_q >= PER_LIM));
        age_d       = (tick && (age_q != 16'hFFFF)) ? age_q + 16'd1 : age_q;
        gap_d       = (tick && (gap_q < GAP_LIM)) ? gap_q + 16'd1 : gap_q;
        to_d        = (tick && (state_q == WAIT) && (to_q < TO_LIM)) ? to_q + 16'd1 : to_q;

        case (state_q)
            IDLE: begin
                if ((|pend_q) && valid_q && (age_q < FRESH_LIM)) begin
                    state_d = REPORT;
                    ack_d   = pend_d;
                    res_d   = 1'b1;
                end else if ((|pend_q) || pend_auto_q) begin
                    state_d = GAP;
                    retry_d = '0;
                end
            end
            GAP: begin
                if (gap_q >= GAP_LIM) begin
                    state_d = START;
                    start_d = 1'b1;
                end
            end
            START: begin
                gap_d   = '0;
                to_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completed frame takes priority over a timeout in the same cycle.
                if (rd_done && rd_ok) begin
                    hum_d   = rd_humidity;
                    temp_d  = rd_temperature;
                    valid_d = 1'b1;
                    age_d   = '0;
                    state_d = REPORT;
                    ack_d   = pend_d;
                    res_d   = 1'b1;
                end else if (rd_done || (to_q >= TO_LIM)) begin
                    if (fail_q != 8'hFF) begin
                        fail_d = fail_q + 8'd1;
                    end
                    if (retry_q < RETRY_LIM) begin
                        retry_d = retry_q + RW'(1);
                        state_d = GAP;
                    end else begin
                        state_d = REPORT;
                        ack_d   = pend_d;
                        res_d   = 1'b0;
                    end
                end
            end
            REPORT: begin
                pend_auto_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            pend_auto_q <= 1'b0;
            retry_q     <= '0;
            age_q       <= '1;
            gap_q       <= GAP_LIM;
            to_q        <= '0;
            fail_q      <= '0;
            hum_q       <= '0;
            temp_q      <= '0;
            valid_q     <= 1'b0;
            ack_q       <= '0;
            res_q       <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_auto_q <= pend_auto_d;
            retry_q     <= retry_d;
            age_q       <= age_d;
            gap_q       <= gap_d;
            to_q        <= to_d;
            fail_q      <= fail_d;
            hum_q       <= hum_d;
            temp_q      <= temp_d;
            valid_q     <= valid_d;
            ack_q       <= ack_d;
            res_q       <= res_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
        end
    end

    assign ack         = ack_q;
    assign result_ok   = res_q;
    assign rd_start    = start_q;
    assign humidity    = hum_q;
    assign temperature = temp_q;
    assign data_valid  = valid_q;
    assign busy        = busy_q;
    assign fail_cnt    = fail_q;

endmodule

// File: tb/tb_dht11_sched.sv
// Directed bench for dht11_sched with shortened ms timing; bench plays the frame reader.
module tb_dht11_sched;

    localparam int CLK_PER_MS = 10;
    localparam int MIN_GAP_MS = 20;
    localparam int FRESH_MS   = 10;
    localparam int PERIOD_MS  = 30;
    localparam int TIMEOUT_MS = 3;
    localparam int MAX_RETRY  = 2;
    // Start-to-start spacing when the gap is binding: full gap, then GAP->START.
    localparam int GAP_CYC  = MIN_GAP_MS * CLK_PER_MS + 2;
    // Start to ack when every attempt times out: full timeout, then WAIT->REPORT.
    localparam int TO_CYC   = TIMEOUT_MS * CLK_PER_MS + 2;
    // Auto refresh with a 5-cycle reader: age hits PERIOD, pend_auto, IDLE->GAP->START.
    localparam int AUTO_CYC = PERIOD_MS * CLK_PER_MS + 4;

    logic       clk = 1'b0;
    logic       reset_p;
    logic [1:0] req;
    logic       auto_en;
    logic [1:0] ack;
    logic       result_ok;
    logic       rd_start;
    logic       rd_done;
    logic       rd_ok;
    logic [7:0] rd_humidity;
    logic [7:0] rd_temperature;
    logic [7:0] humidity;
    logic [7:0] temperature;
    logic       data_valid;
    logic       busy;
    logic [7:0] fail_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    int unsigned cyc = 0;
    int unsigned n_start = 0;
    int unsigned n_ack = 0;
    int unsigned last_start_cyc = 0;
    int unsigned last_ack_cyc = 0;
    int unsigned last_sp = 0;
    logic        have_start = 1'b0;

    int unsigned s_start;
    int unsigned s_ack;

    always #5 clk = ~clk;

    dht11_sched #(
        .CLK_PER_MS (CLK_PER_MS),
        .MIN_GAP_MS (MIN_GAP_MS),
        .FRESH_MS   (FRESH_MS),
        .PERIOD_MS  (PERIOD_MS),
        .TIMEOUT_MS (TIMEOUT_MS),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .clk            (clk),
        .reset_p        (reset_p),
        .req            (req),
        .auto_en        (auto_en),
        .ack            (ack),
        .result_ok      (result_ok),
        .rd_start       (rd_start),
        .rd_done        (rd_done),
        .rd_ok          (rd_ok),
        .rd_humidity    (rd_humidity),
        .rd_temperature (rd_temperature),
        .humidity       (humidity),
        .temperature    (temperature),
        .data_valid     (data_valid),
        .busy           (busy),
        .fail_cnt       (fail_cnt)
    );

    // Pulse monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc <= cyc + 1;
        if (rd_start === 1'b1) begin
            if (have_start) last_sp <= cyc - last_start_cyc;
            have_start     <= 1'b1;
            last_start_cyc <= cyc;
            n_start        <= n_start + 1;
        end
        if (ack !== 2'b00) begin
            n_ack        <= n_ack + 1;
            last_ack_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rd_start !== 1'b1 && n < budget);
        check(tag, 32'(rd_start), 32'd1);
    endtask

    task automatic wait_ack(input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack === 2'b00 && n < budget);
        check(tag, 32'(ack !== 2'b00), 32'd1);
    endtask

    task automatic reply(input int lat, input logic ok, input logic [7:0] h, input logic [7:0] t);
        repeat (lat) @(negedge clk);
        rd_done = 1'b1;
        rd_ok = ok;
        rd_humidity = h;
        rd_temperature = t;
        @(negedge clk);
        rd_done = 1'b0;
        rd_ok = 1'b0;
    endtask

    task automatic pulse_req(input logic [1:0] r);
        req = r;
        @(negedge clk);
        req = 2'b00;
    endtask

    initial begin
        reset_p = 1'b1;
        req = 2'b00;
        auto_en = 1'b0;
        rd_done = 1'b0;
        rd_ok = 1'b0;
        rd_humidity = 8'h00;
        rd_temperature = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({ack, result_ok, rd_start, humidity, temperature, data_valid, busy, fail_cnt}), 32'd0);
        reset_p = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // First read: single requester, good frame.
        s_start = n_start;
        pulse_req(2'b01);
        wait_start(10, "t1_start");
        reply(5, 1'b1, 8'h37, 8'h19);
        check("t1_ack", 32'(ack), 32'h1);
        check("t1_ok", 32'(result_ok), 32'd1);
        check("t1_hum", 32'(humidity), 32'h37);
        check("t1_temp", 32'(temperature), 32'h19);
        check("t1_valid", 32'(data_valid), 32'd1);
        check("t1_nstart", n_start - s_start, 32'd1);
        @(negedge clk);
        check("t1_ack_drop", 32'(ack), 32'h0);

        // Cache hit: ack exactly two cycles after req, no sensor access.
        repeat (20) @(negedge clk);
        s_start = n_start;
        pulse_req(2'b10);
        check("t2_ack_early", 32'(ack), 32'h0);
        @(negedge clk);
        check("t2_ack", 32'(ack), 32'h2);
        check("t2_ok", 32'(result_ok), 32'd1);
        @(negedge clk);
        check("t2_nostart", n_start - s_start, 32'd0);

        // Stale cache, both requesters together, gap still running.
        repeat (120) @(negedge clk);
        s_start = n_start;
        pulse_req(2'b11);
        wait_start(400, "t3_start");
        check("t3_gap", last_sp, 32'(GAP_CYC));
        reply(5, 1'b1, 8'h40, 8'h1A);
        check("t3_ack", 32'(ack), 32'h3);
        check("t3_ok", 32'(result_ok), 32'd1);
        check("t3_hum", 32'(humidity), 32'h40);
        check("t3_nstart", n_start - s_start, 32'd1);

        // Two bad checksums, then good.
        repeat (120) @(negedge clk);
        s_start = n_start;
        s_ack = n_ack;
        pulse_req(2'b01);
        wait_start(400, "t4_start0");
        reply(5, 1'b0, 8'hEE, 8'hEE);
        wait_start(400, "t4_start1");
        check("t4_gap1", last_sp, 32'(GAP_CYC));
        reply(5, 1'b0, 8'hEE, 8'hEE);
        wait_start(400, "t4_start2");
        check("t4_gap2", last_sp, 32'(GAP_CYC));
        reply(5, 1'b1, 8'h41, 8'h1B);
        check("t4_ack", 32'(ack), 32'h1);
        check("t4_ok", 32'(result_ok), 32'd1);
        check("t4_fail", 32'(fail_cnt), 32'd2);
        check("t4_nstart", n_start - s_start, 32'd3);
        check("t4_nack", n_ack - s_ack, 32'd1);
        check("t4_temp", 32'(temperature), 32'h1B);

        // Reader silent: three timeouts, failed report, data kept.
        repeat (120) @(negedge clk);
        pulse_req(2'b10);
        wait_start(400, "t5_start0");
        wait_start(400, "t5_start1");
        wait_start(400, "t5_start2");
        wait_ack(100, "t5_ack_seen");
        check("t5_ack", 32'(ack), 32'h2);
        check("t5_ok", 32'(result_ok), 32'd0);
        check("t5_to_lat", last_ack_cyc - last_start_cyc, 32'(TO_CYC));
        check("t5_fail", 32'(fail_cnt), 32'd5);
        check("t5_hum", 32'(humidity), 32'h41);
        check("t5_valid", 32'(data_valid), 32'd1);

        // Stray rd_done while idle is ignored.
        repeat (5) @(negedge clk);
        rd_done = 1'b1;
        rd_ok = 1'b1;
        rd_humidity = 8'h99;
        @(negedge clk);
        rd_done = 1'b0;
        rd_ok = 1'b0;
        @(negedge clk);
        check("stray_hum", 32'(humidity), 32'h41);
        check("stray_busy", 32'(busy), 32'd0);

        // rd_done in the very cycle the timeout is reached: the frame wins.
        pulse_req(2'b01);
        wait_start(400, "t6_start");
        reply(31, 1'b1, 8'h55, 8'h22);
        check("t6_ack", 32'(ack), 32'h1);
        check("t6_ok", 32'(result_ok), 32'd1);
        check("t6_hum", 32'(humidity), 32'h55);
        check("t6_fail", 32'(fail_cnt), 32'd5);

        // Request held high through ack re-pends and is served again from cache.
        repeat (3) @(negedge clk);
        s_ack = n_ack;
        req = 2'b10;
        @(negedge clk);
        check("t7_ack0", 32'(ack), 32'h0);
        @(negedge clk);
        check("t7_ack1", 32'(ack), 32'h2);
        @(negedge clk);
        check("t7_gap_a", 32'(ack), 32'h0);
        @(negedge clk);
        check("t7_gap_b", 32'(ack), 32'h0);
        @(negedge clk);
        check("t7_ack2", 32'(ack), 32'h2);
        req = 2'b00;
        repeat (5) @(negedge clk);
        check("t7_nack", n_ack - s_ack, 32'd2);

        // Auto refresh: periodic starts, no acks.
        s_ack = n_ack;
        auto_en = 1'b1;
        wait_start(600, "t8_start0");
        reply(5, 1'b1, 8'h30, 8'h10);
        wait_start(600, "t8_start1");
        check("t8_period1", last_sp, 32'(AUTO_CYC));
        reply(5, 1'b1, 8'h31, 8'h11);
        wait_start(600, "t8_start2");
        check("t8_period2", last_sp, 32'(AUTO_CYC));
        reply(5, 1'b1, 8'h32, 8'h12);
        auto_en = 1'b0;
        check("t8_nack", n_ack - s_ack, 32'd0);
        check("t8_hum", 32'(humidity), 32'h32);

        // Asynchronous reset during WAIT.
        repeat (120) @(negedge clk);
        pulse_req(2'b01);
        wait_start(400, "t9_start");
        repeat (3) @(negedge clk);
        check("t9_busy", 32'(busy), 32'd1);
        reset_p = 1'b1;
        #1;
        check("t9_reset_outs", 32'({ack, result_ok, rd_start, humidity, temperature, data_valid, busy, fail_cnt}), 32'd0);
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        s_start = n_start;
        s_ack = n_ack;
        repeat (300) @(negedge clk);
        check("t9_nstart", n_start - s_start, 32'd0);
        check("t9_nack", n_ack - s_ack, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
